// File: rtl/unsigned_div_core_pkg.sv
// unsigned_div_core_pkg: shared state encoding and default sizes for the iterative divider
package unsigned_div_core_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
endpackage

// File: rtl/unsigned_div_core_step.sv
// unsigned_div_core_step: one restoring shift-subtract iteration
module unsigned_div_core_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  always_comb begin
    shifted = {r_i, q_msb_i};
    diff    = shifted - {1'b0, d_i};
    q_bit_o = ~diff[WIDTH];
    r_o     = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/unsigned_div_core.sv
// unsigned_div_core: iterative restoring unsigned divider, one quotient bit per clock
module unsigned_div_core
  import unsigned_div_core_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, q_q, r_q, r_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             div_zero_q, q_bit, accept, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  // The unreachable encoding 2'd3 falls into the default arm and behaves as IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_RUN:   state_d = last ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = start ? ((divisor_in == '0) ? S_DONE : S_RUN) : S_IDLE;
    endcase
  end
  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    ready     = !busy;
    done      = state_q == S_DONE;
    accept    = ready && start;
    quotient  = q_q;
    remainder = r_q;
    div_zero  = div_zero_q;
  end
  unsigned_div_core_step #(.WIDTH(WIDTH)) u_step (
    .r_i    (r_q),
    .q_msb_i(q_q[WIDTH-1]),
    .d_i    (d_q),
    .r_o    (r_nxt),
    .q_bit_o(q_bit)
  );
  // A zero divisor loads the final result directly on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      d_q        <= divisor_in;
      cnt_q      <= '0;
      div_zero_q <= divisor_in == '0;
      q_q        <= (divisor_in == '0) ? '1 : dividend_in;
      r_q        <= (divisor_in == '0) ? dividend_in : '0;
    end else if (state_q == S_RUN) begin
      r_q   <= r_nxt;
      q_q   <= {q_q[WIDTH-2:0], q_bit};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule
